// File: rtl/branch_predictor_if.sv
// Branch predictor bus: IF-stage lookup, ID-slot control and ID-stage resolution.
// The pipeline side uses the master modport, the predictor uses the slave modport.
interface branch_predictor_if;
  // IF stage
  logic [31:0] if_pc;
  logic        if_stall;
  logic        flush;
  logic        pred_taken;
  logic [31:0] pred_target;
  // ID stage
  logic [31:0] id_pc;
  logic        id_branch;
  logic        id_pcsrc;
  logic [31:0] id_target;
  logic        id_stall;
  logic        mispredict;
  logic [31:0] redirect_pc;

  modport master (
    output if_pc, if_stall, flush, id_pc, id_branch, id_pcsrc, id_target, id_stall,
    input  pred_taken, pred_target, mispredict, redirect_pc
  );

  modport slave (
    input  if_pc, if_stall, flush, id_pc, id_branch, id_pcsrc, id_target, id_stall,
    output pred_taken, pred_target, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters. Lookup for the fetch PC is
// combinational; the prediction is carried in an ID slot and compared against
// the branch outcome resolved in ID, raising mispredict/redirect and training
// the table when the branch leaves ID.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 30 - $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bus
);

  localparam int IDX = $clog2(ENTRIES);

  typedef logic [IDX-1:0]   idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  // Table state
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] valid_d;
  tag_t               tag_q    [ENTRIES];
  tag_t               tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  // ID slot holding the prediction made for the instruction now in ID
  logic               id_pred_taken_q;
  logic               id_pred_taken_d;
  logic [31:0]        id_pred_target_q;
  logic [31:0]        id_pred_target_d;

  // Lookup / resolution results
  idx_t               if_idx_s;
  tag_t               if_tag_s;
  idx_t               id_idx_s;
  tag_t               id_tag_s;
  logic               if_hit_s;
  logic               id_hit_s;
  logic               pred_taken_s;
  logic [31:0]        pred_target_s;
  logic [31:0]        id_pc4_s;
  logic               mispredict_s;
  logic [31:0]        redirect_pc_s;

  // Saturating increment: strong-taken stays strong-taken.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    logic [1:0] r;
    case (c)
      2'b00:   r = 2'b01;
      2'b01:   r = 2'b10;
      2'b10:   r = 2'b11;
      2'b11:   r = 2'b11;
      default: r = 2'b01;
    endcase
    return r;
  endfunction

  // Saturating decrement: strong-not-taken stays strong-not-taken.
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    logic [1:0] r;
    case (c)
      2'b00:   r = 2'b00;
      2'b01:   r = 2'b00;
      2'b10:   r = 2'b01;
      2'b11:   r = 2'b10;
      default: r = 2'b01;
    endcase
    return r;
  endfunction

  assign if_idx_s = bus.if_pc[IDX+1:2];
  assign if_tag_s = bus.if_pc[31:IDX+2];
  assign id_idx_s = bus.id_pc[IDX+1:2];
  assign id_tag_s = bus.id_pc[31:IDX+2];
  assign id_pc4_s = bus.id_pc + 32'd4;

  // IF lookup: predict taken only on a tag hit whose counter leans taken.
  always_comb begin
    if_hit_s     = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
    pred_taken_s = if_hit_s && ctr_q[if_idx_s][1];
    if (pred_taken_s) begin
      pred_target_s = target_q[if_idx_s];
    end else begin
      pred_target_s = bus.if_pc + 32'd4;
    end
  end

  // ID resolution: compare the slot's prediction with the real outcome.
  always_comb begin
    redirect_pc_s = id_pc4_s;
    if (bus.id_branch) begin
      mispredict_s = (bus.id_pcsrc != id_pred_taken_q) ||
                     (bus.id_pcsrc && (bus.id_target != id_pred_target_q));
      if (bus.id_pcsrc) begin
        redirect_pc_s = bus.id_target;
      end else begin
        redirect_pc_s = id_pc4_s;
      end
    end else if (id_pred_taken_q) begin
      // A non-branch was predicted taken: fall through to the next instruction.
      mispredict_s = 1'b1;
    end else begin
      mispredict_s = 1'b0;
    end
  end

  // ID slot next state: flush clears and beats stall, stall holds, else load.
  always_comb begin
    if (bus.flush) begin
      id_pred_taken_d  = 1'b0;
      id_pred_target_d = 32'd0;
    end else if (bus.if_stall) begin
      id_pred_taken_d  = id_pred_taken_q;
      id_pred_target_d = id_pred_target_q;
    end else begin
      id_pred_taken_d  = pred_taken_s;
      id_pred_target_d = pred_target_s;
    end
  end

  // Table training once the branch leaves ID; a taken miss evicts the entry.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    id_hit_s = valid_q[id_idx_s] && (tag_q[id_idx_s] == id_tag_s);
    if (bus.id_branch && !bus.id_stall) begin
      if (id_hit_s) begin
        if (bus.id_pcsrc) begin
          ctr_d[id_idx_s]    = ctr_inc(ctr_q[id_idx_s]);
          target_d[id_idx_s] = bus.id_target;
        end else begin
          ctr_d[id_idx_s]    = ctr_dec(ctr_q[id_idx_s]);
        end
      end else if (bus.id_pcsrc) begin
        valid_d[id_idx_s]  = 1'b1;
        tag_d[id_idx_s]    = id_tag_s;
        target_d[id_idx_s] = bus.id_target;
        ctr_d[id_idx_s]    = 2'b10;
      end else begin
        // Not-taken miss: nothing worth remembering.
        valid_d[id_idx_s]  = valid_q[id_idx_s];
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers; reset drops the whole table, the ID slot and any pending write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q          <= '0;
      id_pred_taken_q  <= 1'b0;
      id_pred_target_q <= 32'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q          <= valid_d;
      id_pred_taken_q  <= id_pred_taken_d;
      id_pred_target_q <= id_pred_target_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
    end
  end

  assign bus.pred_taken  = pred_taken_s;
  assign bus.pred_target = pred_target_s;
  assign bus.mispredict  = mispredict_s;
  assign bus.redirect_pc = redirect_pc_s;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a directed vector table with hand-derived
// expectations, then randomized traffic against a behavioural table model.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int IDX     = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  branch_predictor_if bus_if ();

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_stall;
    logic        flush;
    logic [31:0] id_pc;
    logic        id_branch;
    logic        id_pcsrc;
    logic [31:0] id_target;
    logic        id_stall;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_mp;
    logic [31:0] e_rd;
  } vec_t;

  // Behavioural model: plain arrays indexed by (pc/4) mod ENTRIES, counters as ints 0..3.
  bit          mv   [ENTRIES];
  logic [31:0] mtag [ENTRIES];
  logic [31:0] mtgt [ENTRIES];
  int          mctr [ENTRIES];
  bit          ms_taken;
  logic [31:0] ms_tgt;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] m_tag(input logic [31:0] pc);
    return pc >> (IDX + 2);
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int i;
    i = m_idx(pc);
    t = mv[i] && (mtag[i] == m_tag(pc)) && (mctr[i] >= 2);
    tg = t ? mtgt[i] : pc + 32'd4;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      mv[i] = 1'b0; mtag[i] = 32'd0; mtgt[i] = 32'd0; mctr[i] = 1;
    end
    ms_taken = 1'b0;
    ms_tgt   = 32'd0;
  endfunction

  function automatic void m_edge(input vec_t v);
    bit          pt;
    logic [31:0] ptg;
    int          i;
    if (!v.rst_n) begin
      m_reset();
    end else begin
      m_lookup(v.if_pc, pt, ptg);
      if (v.id_branch && !v.id_stall) begin
        i = m_idx(v.id_pc);
        if (mv[i] && mtag[i] == m_tag(v.id_pc)) begin
          if (v.id_pcsrc) begin
            mctr[i] = (mctr[i] < 3) ? mctr[i] + 1 : 3;
            mtgt[i] = v.id_target;
          end else begin
            mctr[i] = (mctr[i] > 0) ? mctr[i] - 1 : 0;
          end
        end else if (v.id_pcsrc) begin
          mv[i] = 1'b1; mtag[i] = m_tag(v.id_pc); mtgt[i] = v.id_target; mctr[i] = 2;
        end
      end
      if (v.flush) begin
        ms_taken = 1'b0; ms_tgt = 32'd0;
      end else if (!v.if_stall) begin
        ms_taken = pt; ms_tgt = ptg;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle (called right after a negedge), check outputs, cross the edge.
  task automatic step(input vec_t v, input bit use_model, input bit do_chk, input string nm);
    bit          pt;
    logic [31:0] ptg;
    logic        emp;
    logic [31:0] erd;
    rst_n            = v.rst_n;
    bus_if.if_pc     = v.if_pc;
    bus_if.if_stall  = v.if_stall;
    bus_if.flush     = v.flush;
    bus_if.id_pc     = v.id_pc;
    bus_if.id_branch = v.id_branch;
    bus_if.id_pcsrc  = v.id_pcsrc;
    bus_if.id_target = v.id_target;
    bus_if.id_stall  = v.id_stall;
    #2;
    if (use_model) begin
      m_lookup(v.if_pc, pt, ptg);
      if (v.id_branch) begin
        emp = (v.id_pcsrc != ms_taken) || (v.id_pcsrc && (v.id_target != ms_tgt));
        erd = v.id_pcsrc ? v.id_target : v.id_pc + 32'd4;
      end else begin
        emp = ms_taken;
        erd = v.id_pc + 32'd4;
      end
    end else begin
      pt = v.e_pt; ptg = v.e_ptgt; emp = v.e_mp; erd = v.e_rd;
    end
    if (do_chk) begin
      chk({nm, " pred_taken"},  {31'd0, bus_if.pred_taken}, {31'd0, pt});
      chk({nm, " pred_target"}, bus_if.pred_target, ptg);
      chk({nm, " mispredict"},  {31'd0, bus_if.mispredict}, {31'd0, emp});
      chk({nm, " redirect_pc"}, bus_if.redirect_pc, erd);
    end
    @(posedge clk);
    m_edge(v);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [31:0] ifpc, input logic ifs, input logic fl,
                              input logic [31:0] idpc, input logic br, input logic src,
                              input logic [31:0] tgt, input logic ids,
                              input logic ept, input logic [31:0] eptgt,
                              input logic emp, input logic [31:0] erd);
    vec_t v;
    v.rst_n = 1'b1; v.if_pc = ifpc; v.if_stall = ifs; v.flush = fl;
    v.id_pc = idpc; v.id_branch = br; v.id_pcsrc = src; v.id_target = tgt; v.id_stall = ids;
    v.e_pt = ept; v.e_ptgt = eptgt; v.e_mp = emp; v.e_rd = erd;
    return v;
  endfunction

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return 32'h100 + 32'($urandom_range(0, 7)) * 32'h40 + 32'($urandom_range(0, 1)) * 32'h4;
  endfunction

  vec_t tbl[$];
  vec_t v;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_reset();

    // Cold sweep
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk(32'(4 * k), 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                       1'b0, 32'(4 * k + 4), 1'b0, 32'h4));
    // Clear slot, then cold taken branch 0x100 -> 0x80
    tbl.push_back(mk(32'h0,   0, 1, 32'h0,   0, 0, 32'h0,   0, 0, 32'h4,   0, 32'h4));
    tbl.push_back(mk(32'h0,   0, 0, 32'h100, 1, 1, 32'h80,  0, 0, 32'h4,   1, 32'h80));
    tbl.push_back(mk(32'h100, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h80,  0, 32'h4));
    // Three more taken: counter saturates
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(32'h100, 0, 0, 32'h100, 1, 1, 32'h80, 0, 1, 32'h80, 0, 32'h80));
    // Two not-taken: still taken after first, flips after second
    tbl.push_back(mk(32'h100, 0, 0, 32'h100, 1, 0, 32'h80,  0, 1, 32'h80,  1, 32'h104));
    tbl.push_back(mk(32'h100, 0, 0, 32'h100, 1, 0, 32'h80,  0, 1, 32'h80,  1, 32'h104));
    tbl.push_back(mk(32'h100, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104, 1, 32'h4));
    // Retrain, then target change 0x80 -> 0x90 (no same-cycle bypass)
    tbl.push_back(mk(32'h40,  0, 0, 32'h100, 1, 1, 32'h80,  0, 0, 32'h44,  1, 32'h80));
    tbl.push_back(mk(32'h100, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h80,  0, 32'h4));
    tbl.push_back(mk(32'h100, 0, 0, 32'h100, 1, 1, 32'h90,  0, 1, 32'h80,  1, 32'h90));
    tbl.push_back(mk(32'h100, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h90,  1, 32'h4));
    // Alias 0x140 evicts 0x100
    tbl.push_back(mk(32'h140, 0, 0, 32'h140, 1, 1, 32'h200, 0, 0, 32'h144, 1, 32'h200));
    tbl.push_back(mk(32'h100, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104, 0, 32'h4));
    tbl.push_back(mk(32'h140, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h200, 0, 32'h4));
    // Flush beats stall, then stall holds cleared slot for 3 cycles
    tbl.push_back(mk(32'h0,   1, 1, 32'h0,   0, 0, 32'h0,   0, 0, 32'h4,   1, 32'h4));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(32'h140, 1, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h200, 0, 32'h4));
    tbl.push_back(mk(32'h140, 0, 0, 32'h300, 1, 0, 32'h0,   1, 1, 32'h200, 0, 32'h304));
    // id_stall on a branch for 2 cycles: exactly one counter step (2 -> 1)
    tbl.push_back(mk(32'h140, 1, 0, 32'h140, 1, 0, 32'h200, 1, 1, 32'h200, 1, 32'h144));
    tbl.push_back(mk(32'h140, 1, 0, 32'h140, 1, 0, 32'h200, 1, 1, 32'h200, 1, 32'h144));
    tbl.push_back(mk(32'h140, 0, 0, 32'h140, 1, 0, 32'h200, 0, 1, 32'h200, 1, 32'h144));
    tbl.push_back(mk(32'h140, 0, 0, 32'h140, 1, 1, 32'h200, 0, 0, 32'h144, 0, 32'h200));
    tbl.push_back(mk(32'h140, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h200, 0, 32'h4));
    // Reset mid-sequence with a concurrent training write, then table is empty
    v = mk(32'h140, 0, 0, 32'h140, 1, 1, 32'h200, 0, 1, 32'h200, 0, 32'h200);
    v.rst_n = 1'b0;
    tbl.push_back(v);
    tbl.push_back(mk(32'h140, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h144, 0, 32'h4));
    tbl.push_back(mk(32'h100, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104, 0, 32'h4));
    // Address wrap
    tbl.push_back(mk(32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0));

    // Initial reset: two cycles, outputs not meaningful yet
    @(negedge clk);
    v = mk(32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h4, 0, 32'h4);
    v.rst_n = 1'b0;
    step(v, 1'b0, 1'b0, "reset");
    step(v, 1'b0, 1'b0, "reset");

    for (int r = 0; r < tbl.size(); r++)
      step(tbl[r], 1'b0, 1'b1, $sformatf("row%0d", r));

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      v.rst_n     = ($urandom_range(0, 99) != 0);
      v.if_pc     = rnd_pc();
      v.if_stall  = ($urandom_range(0, 9) == 0);
      v.flush     = ($urandom_range(0, 11) == 0);
      v.id_pc     = rnd_pc();
      v.id_branch = ($urandom_range(0, 9) < 7);
      v.id_pcsrc  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       v.id_target = 32'h80;
        1:       v.id_target = 32'h90;
        2:       v.id_target = 32'h200;
        default: v.id_target = v.id_pc + 32'd8;
      endcase
      v.id_stall  = ($urandom_range(0, 4) == 0);
      step(v, 1'b1, 1'b1, $sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

IF-stage branch predictor plus ID-stage resolution check for the RV32 pipeline. Predicts direction and target for the fetch PC from a direct-mapped branch target buffer with 2-bit saturating counters. Holds each prediction in an ID-stage slot and compares it against the resolved branch outcome (pcsrc and target produced in ID). Raises a mispredict/redirect and trains the table.

## Interface
- ENTRIES, 16: BTB entries; power of 2, at least 2; index = pc[IDX+1:2], IDX = log2(ENTRIES).
- TAG_W, 30-IDX: tag width = pc[31:IDX+2].

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset: synchronous, active-low
- if_pc  in  32  fetch PC for lookup
- if_stall  in  1  hold ID slot (IF/ID not advancing)
- flush  in  1  clear ID slot (IF/ID being bubbled)
- pred_taken  out  1  IF prediction: branch taken
- pred_target  out  32  IF next-PC prediction
- id_pc  in  32  PC of instruction in ID
- id_branch  in  1  instruction in ID is a conditional branch
- id_pcsrc  in  1  resolved direction from ID comparison
- id_target  in  32  resolved branch target (id_pc + imm)
- id_stall  in  1  ID instruction not leaving this cycle (suppresses training)
- mispredict  out  1  ID prediction wrong; flush IF/ID
- redirect_pc  out  32  correct next PC when mispredict=1

## Operation
- Entry fields: valid, tag[TAG_W], target[32], ctr[2].
- Lookup (combinational): hit = valid[idx] && tag[idx]==if_pc tag bits.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4.
- ID slot regs: id_pred_taken, id_pred_target.
  - flush=1: both cleared to 0. Flush wins over if_stall.
  - else if_stall=1: hold.
  - else: load pred_taken, pred_target.
- Resolution (combinational), with pc4 = id_pc+4:
  - id_branch=1: mispredict = (id_pcsrc != id_pred_taken) || (id_pcsrc && id_target != id_pred_target).
    - redirect_pc = id_pcsrc ? id_target : pc4.
  - id_branch=0 and id_pred_taken=1: mispredict=1, redirect_pc=pc4.
  - otherwise: mispredict=0, redirect_pc=pc4.
- Training occurs when id_branch && !id_stall. Entry is indexed and tagged by id_pc.
  - Hit, taken: ctr = min(ctr+1, 3); target = id_target.
  - Hit, not-taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate (overwrite) with valid=1, tag, target=id_target, ctr=2'b10.
  - Miss, not-taken: no change.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Replacement is direct-mapped. An aliasing taken branch evicts the existing entry.

## Timing
- Reset (rst_n=0 at clock edge): all valid=0, ctr=01, tag=0, target=0; id_pred_taken=0, id_pred_target=0.
- Reset outputs: pred_taken=0, pred_target=if_pc+4, mispredict=0 when id_branch=0.
- Reset mid-operation discards all entries and the ID slot; a concurrent training write is dropped.
- Lookup and resolution: zero-cycle, purely combinational from inputs and state.
- Training write lands at the clock edge and is visible to lookup the next cycle.
- Same-cycle lookup and training of the same index: lookup returns pre-write contents; no bypass.
- Prediction for if_pc appears in the ID slot one cycle later, after an edge with if_stall=0 and flush=0.
- id_stall=1 with id_branch=1: mispredict/redirect_pc still driven; no table update. Training happens once, on the cycle the branch leaves ID.
- Address arithmetic: 32-bit, wraps modulo 2^32; 0xFFFFFFFC+4 = 0x00000000.

## Test plan
- Cold table: reset 2 cycles, sweep if_pc 0x0..0x3C -> pred_taken=0, pred_target=if_pc+4; mispredict=0.
- Cold taken branch: id_pc=0x100, id_branch=1, id_pcsrc=1, id_target=0x80, slot cleared.
  - Required: mispredict=1, redirect_pc=0x80.
  - Next cycle, if_pc=0x100: pred_taken=1, pred_target=0x80.
- Counter hysteresis on id_pc=0x100:
  - After 3 more taken: ctr=11.
  - One not-taken: still predicts taken.
  - Second not-taken: pred_taken=0, pred_target=0x104.
  - Not-taken with id_pred_taken=1: mispredict=1, redirect_pc=0x104.
- Alias (ENTRIES=16): entry 0x100→0x80 valid, lookup 0x140 -> miss, pred_taken=0. Taken 0x140→0x200 trains -> 0x100 now misses.
- Target change: 0x100 predicted taken to 0x80, resolves taken to 0x90 -> mispredict=1, redirect_pc=0x90; next lookup pred_target=0x90.
- Slot control:
  - flush=1 and if_stall=1 together -> slot cleared.
  - if_stall=1 alone for 3 cycles -> slot holds.
  - id_stall=1 on a branch for 2 cycles -> single counter step.
  - rst_n low mid-sequence -> table empty afterward.
